mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the two operands read from the register file (after forwarding) and owns the architectural HI/LO registers.
- Serves mult/multu/div/divu with a fixed multi-cycle latency, plus mthi/mtlo.
- Exposes Busy so the hazard unit can stall later HI/LO-touching instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high.
- Start  input  1  one-cycle pulse from E-stage control: the instruction in E is an MDU instruction.
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  rs operand (forwarded RD1).
- B  input  32  rt operand (forwarded RD2).
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, cycle counter=0, pending result discarded. Reset mid-operation aborts the operation; HI/LO stay 0.
- Busy is defined as (counter != 0) and is driven from a register, not from Start.
- Accept rule: on an edge with Start=1, Busy=0 and MDUOp in 1..4:
  - compute and latch the 64-bit result into internal temporaries (HI_t, LO_t);
  - load counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
- Timing: if the accept edge is edge 0, Busy=1 in the N cycles that follow it.
  - At edge N, HI<=HI_t, LO<=LO_t, and counter reaches 0, so Busy=0.
  - New HI/LO values are visible in the cycle Busy falls.
- Counter: decrements by 1 on each non-reset edge while nonzero.
- States: IDLE (counter=0) and RUN (counter>0). The IDLE->RUN and RUN->IDLE transitions above are the only ones.
- mult: signed 32x32 product; HI=product[63:32], LO=product[31:0].
- multu: same, with unsigned operands.
- div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, op 3 or 4): Busy still asserted for DIV_CYCLES; HI/LO keep their previous values at the commit edge.
- mthi/mtlo (Start=1, Busy=0): HI<=A (or LO<=A) on that edge, with no Busy assertion.
- Start=1 while Busy=1: ignored entirely for every op. Operands, the in-flight result and the counter are unaffected. The hazard unit guarantees this never happens legally; the block must still be safe.
- Start=1 with MDUOp 0 or 7: no state change.
- Start=0: MDUOp/A/B ignored.
- HI/LO change only at reset, at a commit edge, or at an accepted mthi/mtlo. They are stable otherwise, so mfhi/mflo reads are combinational from the outputs.

Test Plan:
- Reset, then a mult: reset high 2 cycles -> HI=LO=0, Busy=0. Then Start=1, mult, A=0xFFFFFFFE (-2), B=3 -> Busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu and back-to-back: multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Start a second multu (A=3, B=4) in the first cycle Busy=0 -> accepted; LO=12, HI=0 five cycles later.
- Signed divide and overflow: div A=-7 (0xFFFFFFF9), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and busy guard: HI=0x11, LO=0x22 preset via mthi/mtlo. divu with B=0 -> Busy for 10 cycles, then HI=0x11, LO=0x22 unchanged. Pulse mult and mtlo A=0x99 while Busy -> no effect on any output or on the Busy duration.
- mthi/mtlo immediacy: mthi A=0xDEADBEEF, Busy=0 -> HI=0xDEADBEEF on the next cycle, Busy stays 0. mtlo A=0x1234 the following cycle -> LO=0x1234.
- Reset mid-operation: start div A=100, B=7, assert reset at Busy cycle 4 -> next cycle Busy=0, HI=LO=0, and no commit of 14/2 ever appears.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/multu/div/divu
// with a fixed latency and applies mthi/mtlo immediately.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state_o
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q;
    logic [CW-1:0] counter_q;
    logic [31:0]   hi_q, lo_q, hi_t_q, lo_t_q;
    logic          commit_q;

    logic signed [63:0] prod_s_d;
    logic [63:0]        prod_u_d;
    logic [31:0]        divisor_d, abs_a_d, abs_b_d, quot_u_d, rem_u_d;
    logic [31:0]        quot_s_d, rem_s_d, quot_du_d, rem_du_d;

    assign prod_s_d = $signed(A) * $signed(B);
    assign prod_u_d = {32'd0, A} * {32'd0, B};

    // Division runs on magnitudes so the -2^31 / -1 case wraps cleanly to
    // 0x80000000 instead of relying on signed-overflow behaviour.
    assign divisor_d = (B == 32'd0) ? 32'd1 : B;
    assign abs_a_d   = A[31] ? (32'd0 - A) : A;
    assign abs_b_d   = divisor_d[31] ? (32'd0 - divisor_d) : divisor_d;
    assign quot_u_d  = abs_a_d / abs_b_d;
    assign rem_u_d   = abs_a_d % abs_b_d;
    assign quot_s_d  = (A[31] ^ B[31]) ? (32'd0 - quot_u_d) : quot_u_d;
    assign rem_s_d   = A[31] ? (32'd0 - rem_u_d) : rem_u_d;
    assign quot_du_d = A / divisor_d;
    assign rem_du_d  = A % divisor_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_t_q    <= '0;
            lo_t_q    <= '0;
            commit_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (MDUOp)
                            3'd1: begin
                                hi_t_q    <= prod_s_d[63:32];
                                lo_t_q    <= prod_s_d[31:0];
                                commit_q  <= 1'b1;
                                counter_q <= CW'(MULT_CYCLES);
                                state_q   <= RUN;
                            end
                            3'd2: begin
                                hi_t_q    <= prod_u_d[63:32];
                                lo_t_q    <= prod_u_d[31:0];
                                commit_q  <= 1'b1;
                                counter_q <= CW'(MULT_CYCLES);
                                state_q   <= RUN;
                            end
                            3'd3: begin
                                hi_t_q    <= rem_s_d;
                                lo_t_q    <= quot_s_d;
                                commit_q  <= (B != 32'd0);
                                counter_q <= CW'(DIV_CYCLES);
                                state_q   <= RUN;
                            end
                            3'd4: begin
                                hi_t_q    <= rem_du_d;
                                lo_t_q    <= quot_du_d;
                                commit_q  <= (B != 32'd0);
                                counter_q <= CW'(DIV_CYCLES);
                                state_q   <= RUN;
                            end
                            3'd5:    hi_q <= A;
                            3'd6:    lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Start is ignored here; the in-flight result just counts down.
                    counter_q <= counter_q - CW'(1);
                    if (counter_q == CW'(1)) begin
                        state_q <= IDLE;
                        if (commit_q) begin
                            hi_q <= hi_t_q;
                            lo_q <= lo_t_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy        = (state_q == RUN);
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, divide-by-zero, busy guard,
// mthi/mtlo and reset abort, checked against hand-computed values.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;
    logic        dbg_state;

    int tests  = 0;
    int failed = 0;
    int cnt;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle Start pulse; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        tick();
        Start = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
    endtask

    // Counts cycles with Busy high, bounded so a stuck Busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
        #1;
        tick(); tick();
        reset = 1'b0;
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // mult -2 * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_state_run", 32'(dbg_state), 32'd1);
        check("mult_hi_held", HI, 32'h0);
        wait_idle(cnt);
        check("mult_busy_cycles", 32'(cnt), 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        // multu, then back-to-back multu in the first idle cycle
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cnt);
        check("multu_busy_cycles", 32'(cnt), 32'd5);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        issue(3'd2, 32'd3, 32'd4);
        check("b2b_busy", 32'(Busy), 32'd1);
        wait_idle(cnt);
        check("b2b_busy_cycles", 32'(cnt), 32'd5);
        check("b2b_hi", HI, 32'h0);
        check("b2b_lo", LO, 32'd12);

        // signed divide -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cnt);
        check("div_busy_cycles", 32'(cnt), 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cnt);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0);

        // divu 100 / 7
        issue(3'd4, 32'd100, 32'd7);
        wait_idle(cnt);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // preset, then divide by zero with ignored starts while busy
        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        check("preset_hi", HI, 32'h11);
        check("preset_lo", LO, 32'h22);
        issue(3'd4, 32'd5, 32'd0);
        Start = 1'b1; MDUOp = 3'd1; A = 32'd7; B = 32'd7;
        tick();
        Start = 1'b1; MDUOp = 3'd6; A = 32'h99; B = 32'd0;
        tick();
        Start = 1'b0; MDUOp = 3'd0; A = '0;
        check("guard_lo", LO, 32'h22);
        check("guard_busy", 32'(Busy), 32'd1);
        wait_idle(cnt);
        check("divz_busy_cycles", 32'(cnt + 2), 32'd10);
        check("divz_hi", HI, 32'h11);
        check("divz_lo", LO, 32'h22);
        tick(); tick(); tick(); tick(); tick();
        check("guard_no_late_mult_busy", 32'(Busy), 32'd0);
        check("guard_no_late_mult_lo", LO, 32'h22);

        // no-op ops 0 and 7
        issue(3'd0, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1);
        check("nop_busy", 32'(Busy), 32'd0);
        check("nop_hi", HI, 32'h11);
        check("nop_lo", LO, 32'h22);

        // mthi / mtlo immediacy
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi", HI, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(Busy), 32'd0);
        issue(3'd6, 32'h0000_1234, 32'h0);
        check("mtlo_lo", LO, 32'h0000_1234);
        check("mtlo_hi", HI, 32'hDEAD_BEEF);

        // reset in busy cycle 4 of a div aborts it
        issue(3'd3, 32'd100, 32'd7);
        tick(); tick(); tick();
        check("abort_busy_before", 32'(Busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_late_hi", HI, 32'h0);
        check("abort_late_lo", LO, 32'h0);
        check("abort_late_busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
